// File: rtl/snk68_sound_pkg.sv
// Shared types and default constants for the 68k <-> Z80 sound mailbox.
package snk68_sound_pkg;

  typedef logic [7:0] latch_byte_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } nmi_state_e;

  localparam int unsigned NMI_PULSE_LEN_DFLT = 16;
  localparam int unsigned FIFO_DEPTH_DFLT    = 4;
  localparam int unsigned NMI_CNT_W          = 8;

endpackage

// File: rtl/sound_latch_bridge_if.sv
// Bus bundle between the address decoder side and the sound latch bridge.
interface sound_latch_bridge_if;
  import snk68_sound_pkg::*;

  logic        m68k_latch_cs;
  logic        m68k_uds_n;
  latch_byte_t m68k_din;
  logic        z80_latch_read_cs;
  logic        z80_latch_cs;
  logic        z80_rd_n;
  logic        z80_wr_n;
  latch_byte_t z80_dout;

  latch_byte_t m68k_latch_dout;
  latch_byte_t z80_latch_dout;
  logic        z80_nmi_n;
  logic        latch_pending;
  logic        latch_overflow;

  modport master (
    output m68k_latch_cs, m68k_uds_n, m68k_din, z80_latch_read_cs,
           z80_latch_cs, z80_rd_n, z80_wr_n, z80_dout,
    input  m68k_latch_dout, z80_latch_dout, z80_nmi_n, latch_pending,
           latch_overflow
  );

  modport slave (
    input  m68k_latch_cs, m68k_uds_n, m68k_din, z80_latch_read_cs,
           z80_latch_cs, z80_rd_n, z80_wr_n, z80_dout,
    output m68k_latch_dout, z80_latch_dout, z80_nmi_n, latch_pending,
           latch_overflow
  );

endinterface

// File: rtl/sound_latch_bridge_strobe_edge_det.sv
// Rising-edge detector: registers a strobe term and flags its 0->1 transition
// one clock later, so a long-held select yields exactly one event.
module strobe_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_term,
  output logic o_rise_c
);

  logic r_term;
  logic r_term_d;

  // Two-deep history of the strobe term.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_term   <= 1'b0;
      r_term_d <= 1'b0;
    end else begin
      r_term   <= i_term;
      r_term_d <= r_term;
    end
  end

  assign o_rise_c = r_term & ~r_term_d;

endmodule

// File: rtl/sound_latch_bridge.sv
// 68000 <-> Z80 sound mailbox: soundlatch (68k->Z80), soundlatch2 (Z80->68k),
// Z80 NMI pulse generation and a pending-command flag.
// Optional build macro SOUND_LATCH_FIFO_EN turns soundlatch into a FIFO of
// FIFO_DEPTH bytes with a sticky overflow flag.
module sound_latch_bridge
  import snk68_sound_pkg::*;
#(
  parameter int unsigned NMI_PULSE_LEN = NMI_PULSE_LEN_DFLT,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  sound_latch_bridge_if.slave  bus
);

  localparam logic [NMI_CNT_W-1:0] NMI_RELOAD = NMI_CNT_W'(NMI_PULSE_LEN - 1);

  logic w_m68k_wr_ev;
  logic w_z80_rd_ev;
  logic w_z80_wr_ev;
  logic w_nmi_trig;

  strobe_edge_det u_m68k_wr_det (
    .clk      (clk),
    .reset    (reset),
    .i_term   (bus.m68k_latch_cs & ~bus.m68k_uds_n),
    .o_rise_c (w_m68k_wr_ev)
  );

  strobe_edge_det u_z80_rd_det (
    .clk      (clk),
    .reset    (reset),
    .i_term   (bus.z80_latch_cs & ~bus.z80_rd_n),
    .o_rise_c (w_z80_rd_ev)
  );

  strobe_edge_det u_z80_wr_det (
    .clk      (clk),
    .reset    (reset),
    .i_term   (bus.z80_latch_cs & ~bus.z80_wr_n),
    .o_rise_c (w_z80_wr_ev)
  );

  // soundlatch2: Z80 reply byte; 68k reads are side-effect free.
  latch_byte_t r_latch2;

  // Capture the Z80 reply on its write event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch2 <= '0;
    end else if (w_z80_wr_ev) begin
      r_latch2 <= bus.z80_dout;
    end
  end

  assign bus.m68k_latch_dout = r_latch2;

  // NMI pulse generator.
  nmi_state_e               r_state;
  nmi_state_e               w_state_nx;
  logic [NMI_CNT_W-1:0]     r_nmi_cnt;
  logic [NMI_CNT_W-1:0]     w_nmi_cnt_nx;
  logic                     r_nmi_n;
  logic                     w_nmi_n_nx;

  // NMI state, counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_nmi_cnt <= '0;
      r_nmi_n   <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_nmi_cnt <= w_nmi_cnt_nx;
      r_nmi_n   <= w_nmi_n_nx;
    end
  end

  // NMI next state: a trigger during PULSE only reloads, so the line stays low.
  always_comb begin
    w_state_nx   = r_state;
    w_nmi_cnt_nx = r_nmi_cnt;
    w_nmi_n_nx   = r_nmi_n;
    case (r_state)
      IDLE: begin
        if (w_nmi_trig) begin
          w_state_nx   = PULSE;
          w_nmi_cnt_nx = NMI_RELOAD;
          w_nmi_n_nx   = 1'b0;
        end
      end
      PULSE: begin
        if (w_nmi_trig) begin
          w_nmi_cnt_nx = NMI_RELOAD;
        end else if (r_nmi_cnt == '0) begin
          w_state_nx = IDLE;
          w_nmi_n_nx = 1'b1;
        end else begin
          w_nmi_cnt_nx = r_nmi_cnt - NMI_CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_nmi_n_nx = 1'b1;
      end
    endcase
  end

  assign bus.z80_nmi_n = r_nmi_n;

`ifdef SOUND_LATCH_FIFO_EN

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CW = FIFO_AW + 1;

  latch_byte_t          r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW-1:0]   w_rd_ptr_nx;
  logic [FIFO_CW-1:0]   r_count;
  logic [FIFO_CW-1:0]   w_count_nx;
  latch_byte_t          r_head;
  latch_byte_t          w_head_nx;
  logic                 r_pending;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_unused_ok;

  assign w_full      = (r_count == FIFO_CW'(FIFO_DEPTH));
  assign w_pop       = w_z80_rd_ev & (r_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push      = w_m68k_wr_ev & (~w_full | w_pop);
  assign w_drop      = w_m68k_wr_ev & ~w_push;
  assign w_rd_ptr_nx = r_rd_ptr + FIFO_AW'(w_pop);
  // Re-arm the NMI while commands remain after a pop.
  assign w_nmi_trig  = w_m68k_wr_ev | (w_pop & (w_count_nx != '0));
  assign w_unused_ok = &{1'b0, bus.z80_latch_read_cs};

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + FIFO_CW'(1);
      2'b01:   w_count_nx = r_count - FIFO_CW'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // Next head byte; the incoming byte is the head when it lands in an empty slot chain.
  always_comb begin
    w_head_nx = r_head;
    if (w_count_nx != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nx)) begin
        w_head_nx = bus.m68k_din;
      end else begin
        w_head_nx = r_fifo[w_rd_ptr_nx];
      end
    end
  end

  // FIFO storage, pointers, head register and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.m68k_din;
        r_wr_ptr         <= r_wr_ptr + FIFO_AW'(1);
      end
      r_rd_ptr  <= w_rd_ptr_nx;
      r_count   <= w_count_nx;
      r_head    <= w_head_nx;
      r_pending <= (w_count_nx != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.z80_latch_dout = r_head;
  assign bus.latch_pending  = r_pending;
  assign bus.latch_overflow = r_overflow;

`else

  latch_byte_t r_latch;
  logic        r_pending;
  logic        w_unused_ok;

  assign w_nmi_trig  = w_m68k_wr_ev;
  assign w_unused_ok = &{1'b0, bus.z80_latch_read_cs, 5'(FIFO_DEPTH)};

  // Single-byte soundlatch; a new command beats a simultaneous Z80 read for pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_m68k_wr_ev) begin
        r_latch   <= bus.m68k_din;
        r_pending <= 1'b1;
      end else if (w_z80_rd_ev) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.z80_latch_dout = r_latch;
  assign bus.latch_pending  = r_pending;
  assign bus.latch_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Self-checking bench for sound_latch_bridge: directed test-plan sequences with
// literal expectations, then randomized bus activity against a behavioural model.
module tb_sound_latch_bridge;

  localparam int unsigned N = 16;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sound_latch_bridge_if bus ();

  sound_latch_bridge #(
    .NMI_PULSE_LEN (N),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model state (reset values).
  logic [7:0] m_latch   = 8'h00;
  logic [7:0] m_latch2  = 8'h00;
  logic       m_pending = 1'b0;
  logic       m_ovf     = 1'b0;
  int         m_nmi_left = 0;
  logic [7:0] m_q[$];
  // Term history: bit0 = sampled one edge ago, bit1 = two edges ago.
  logic [1:0] h_wr = 2'b00;
  logic [1:0] h_rd = 2'b00;
  logic [1:0] h_zw = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;
  int low_cnt = 0;
  int falls   = 0;
  logic prev_nmi = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event happens one clock after the term rises; state changes on the next edge.
  task automatic model_step();
    logic ev_wr, ev_rd, ev_zw, rearm, pop;
    logic t_wr, t_rd, t_zw;
    t_wr = bus.m68k_latch_cs & ~bus.m68k_uds_n;
    t_rd = bus.z80_latch_cs & ~bus.z80_rd_n;
    t_zw = bus.z80_latch_cs & ~bus.z80_wr_n;
    if (reset) begin
      m_latch = 8'h00; m_latch2 = 8'h00; m_pending = 1'b0; m_ovf = 1'b0;
      m_nmi_left = 0; m_q.delete();
      h_wr = 2'b00; h_rd = 2'b00; h_zw = 2'b00;
    end else begin
      ev_wr = h_wr[0] & ~h_wr[1];
      ev_rd = h_rd[0] & ~h_rd[1];
      ev_zw = h_zw[0] & ~h_zw[1];
      rearm = 1'b0;
      pop   = 1'b0;
`ifdef SOUND_LATCH_FIFO_EN
      pop = ev_rd && (m_q.size() != 0);
      if (pop) void'(m_q.pop_front());
      if (ev_wr) begin
        if (m_q.size() < int'(D)) m_q.push_back(bus.m68k_din);
        else m_ovf = 1'b1;
      end
      if (m_q.size() != 0) m_latch = m_q[0];
      m_pending = (m_q.size() != 0);
      rearm = pop && (m_q.size() != 0);
`else
      if (ev_wr) m_latch = bus.m68k_din;
      if (ev_wr) m_pending = 1'b1;
      else if (ev_rd) m_pending = 1'b0;
`endif
      if (ev_zw) m_latch2 = bus.z80_dout;
      if (ev_wr || rearm) m_nmi_left = int'(N);
      else if (m_nmi_left > 0) m_nmi_left--;
      h_wr = {h_wr[0], t_wr};
      h_rd = {h_rd[0], t_rd};
      h_zw = {h_zw[0], t_zw};
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, drive 2 units later.
  task automatic tick();
    @(negedge clk);
    chk("z80_latch_dout",  32'(bus.z80_latch_dout),  32'(m_latch));
    chk("m68k_latch_dout", 32'(bus.m68k_latch_dout), 32'(m_latch2));
    chk("z80_nmi_n",       32'(bus.z80_nmi_n),       32'(m_nmi_left == 0));
    chk("latch_pending",   32'(bus.latch_pending),   32'(m_pending));
    chk("latch_overflow",  32'(bus.latch_overflow),  32'(m_ovf));
    if (bus.z80_nmi_n == 1'b0) low_cnt++;
    if (prev_nmi && !bus.z80_nmi_n) falls++;
    prev_nmi = bus.z80_nmi_n;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle();
    bus.m68k_latch_cs = 1'b0; bus.m68k_uds_n = 1'b1; bus.m68k_din = 8'h00;
    bus.z80_latch_read_cs = 1'b0; bus.z80_latch_cs = 1'b0;
    bus.z80_rd_n = 1'b1; bus.z80_wr_n = 1'b1; bus.z80_dout = 8'h00;
  endtask

  task automatic m68k_write(input logic [7:0] d, input int hold);
    bus.m68k_latch_cs = 1'b1; bus.m68k_uds_n = 1'b0; bus.m68k_din = d;
    ticks(hold);
    bus.m68k_latch_cs = 1'b0; bus.m68k_uds_n = 1'b1;
  endtask

  task automatic z80_read(input int hold);
    bus.z80_latch_cs = 1'b1; bus.z80_rd_n = 1'b0;
    ticks(hold);
    bus.z80_latch_cs = 1'b0; bus.z80_rd_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    ticks(3);
    reset = 1'b0;
    ticks(10);
    chk("reset nmi_n",    32'(bus.z80_nmi_n),       32'h1);
    chk("reset pending",  32'(bus.latch_pending),   32'h0);
    chk("reset z80 dout", 32'(bus.z80_latch_dout),  32'h00);
    chk("reset 68k dout", 32'(bus.m68k_latch_dout), 32'h00);

    // Long-held 68k write gives one command and one 16-clock NMI.
    low_cnt = 0; falls = 0;
    m68k_write(8'h5A, 6);
    ticks(25);
    chk("wr5A z80 dout",   32'(bus.z80_latch_dout), 32'h5A);
    chk("wr5A pending",    32'(bus.latch_pending),  32'h1);
    chk("wr5A nmi low",    32'(low_cnt),            32'd16);
    chk("wr5A nmi falls",  32'(falls),              32'd1);

    // Z80 read clears pending two clocks after RD falls.
    bus.z80_latch_cs = 1'b1; bus.z80_rd_n = 1'b0;
    tick();
    chk("rd pending +1",  32'(bus.latch_pending), 32'h1);
    tick();
    chk("rd pending +2",  32'(bus.latch_pending), 32'h0);
    tick();
    bus.z80_latch_cs = 1'b0; bus.z80_rd_n = 1'b1;
    ticks(3);
    chk("rd z80 dout",    32'(bus.z80_latch_dout), 32'h5A);

    bus.z80_latch_cs = 1'b1; bus.z80_wr_n = 1'b0; bus.z80_dout = 8'hC3;
    ticks(2);
    bus.z80_latch_cs = 1'b0; bus.z80_wr_n = 1'b1;
    ticks(3);
    chk("zwr 68k dout",   32'(bus.m68k_latch_dout), 32'hC3);

    // Command write and Z80 read edge in the same cycle: set wins.
    m68k_write(8'h22, 3);
    ticks(20);
    bus.m68k_latch_cs = 1'b1; bus.m68k_uds_n = 1'b0; bus.m68k_din = 8'h11;
    bus.z80_latch_cs  = 1'b1; bus.z80_rd_n   = 1'b0;
    ticks(3);
    bus_idle();
    ticks(3);
    chk("same pending",   32'(bus.latch_pending),  32'h1);
    chk("same z80 dout",  32'(bus.z80_latch_dout), 32'h11);
    ticks(25);

    // Second write 8 clocks into the pulse extends it without a new edge.
    low_cnt = 0; falls = 0;
    m68k_write(8'hAA, 2);
    ticks(6);
    m68k_write(8'hBB, 2);
    ticks(30);
    chk("ext nmi low",    32'(low_cnt), 32'd24);
    chk("ext nmi falls",  32'(falls),   32'd1);

    // Five pushes, then five pops.
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(2);
    for (int i = 1; i <= 5; i++) begin
      m68k_write(8'(i), 2);
      ticks(2);
    end
    ticks(20);
`ifdef SOUND_LATCH_FIFO_EN
    chk("fill overflow",  32'(bus.latch_overflow), 32'h1);
`else
    chk("fill overflow",  32'(bus.latch_overflow), 32'h0);
`endif
    chk("fill pending",   32'(bus.latch_pending),  32'h1);
    for (int i = 1; i <= 5; i++) begin
`ifdef SOUND_LATCH_FIFO_EN
      chk("pop data", 32'(bus.z80_latch_dout), (i <= 4) ? 32'(i) : 32'h04);
`else
      chk("pop data", 32'(bus.z80_latch_dout), 32'h05);
`endif
      z80_read(2);
      ticks(2);
    end
    ticks(20);
    chk("drain pending",  32'(bus.latch_pending), 32'h0);
`ifdef SOUND_LATCH_FIFO_EN
    chk("drain z80 dout", 32'(bus.z80_latch_dout), 32'h04);
`else
    chk("drain z80 dout", 32'(bus.z80_latch_dout), 32'h05);
`endif

    // Randomized bus activity with occasional resets, including mid-pulse.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.m68k_latch_cs = ~bus.m68k_latch_cs;
      if ($urandom_range(0, 3) == 0) bus.m68k_uds_n    = ~bus.m68k_uds_n;
      bus.m68k_din = 8'($urandom);
      if ($urandom_range(0, 5) == 0) bus.z80_latch_cs  = ~bus.z80_latch_cs;
      if ($urandom_range(0, 3) == 0) bus.z80_rd_n      = ~bus.z80_rd_n;
      if ($urandom_range(0, 4) == 0) bus.z80_wr_n      = ~bus.z80_wr_n;
      bus.z80_dout = 8'($urandom);
      bus.z80_latch_read_cs = 1'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    bus_idle();
    ticks(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
